// File: rtl/vga_cell_fetch_if.sv
// vga_cell_fetch_if
// Bundles the display-side signals of vga_cell_fetch: the cell RAM read
// port (address out, data back one cycle later) and the VGA pin outputs.
//
// Signals:
//   o_addr        10  RAM read address {row[4:0], col[4:0]}
//   i_data         4  RAM read data, valid one cycle after o_addr
//   o_hsync        1  active-low horizontal sync
//   o_vsync        1  active-low vertical sync
//   o_red/grn/blu  3  pixel colour
//   o_frame_start  1  one-cycle pulse with output pixel (0,0)
//
// Modports:
//   master  the fetch block (drives address and pins, reads RAM data)
//   slave   RAM model / monitor side
//
// There is no valid/ready handshake on this bus: the RAM read port is a
// fixed one-cycle-latency pipe, so i_data in cycle n+1 always belongs to
// the o_addr presented in cycle n. Nothing can stall it.
interface vga_cell_fetch_if;
  logic [9:0] o_addr;
  logic [3:0] i_data;
  logic       o_hsync;
  logic       o_vsync;
  logic [2:0] o_red;
  logic [2:0] o_grn;
  logic [2:0] o_blu;
  logic       o_frame_start;

  modport master (
    output o_addr, o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame_start,
    input  i_data
  );

  modport slave (
    input  o_addr, o_hsync, o_vsync, o_red, o_grn, o_blu, o_frame_start,
    output i_data
  );
endinterface

// File: rtl/vga_cell_fetch.sv
// vga_cell_fetch
// Scans 640x480@60 VGA timing, addresses a 32x32 grid of 4-bit cells held
// in an external RAM (each cell covers CELL_W x CELL_H pixels), absorbs the
// RAM's one-cycle read latency and maps each word to 3-bit-per-channel RGB.
//
// Ports:
//   i_clk     pixel clock, single clock domain
//   i_rst_n   asynchronous active-low reset
//   i_enable  high = scan; low = counters held at origin, outputs blank
//   vga       vga_cell_fetch_if.master (RAM read port + VGA pins)
//
// Pipeline:
//   stage 0  h/v and cell counters; o_addr = {row, col} combinationally
//   stage 1  active / sync / frame flags from stage 0, lined up with i_data
//   stage 2  registered colour, syncs and frame pulse
// Every output therefore shows pixel (h,v) two cycles after the counters
// sat at (h,v).
module vga_cell_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CELL_W   = 20,
  parameter int CELL_H   = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  vga_cell_fetch_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int CWW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int CHW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]  H_ONE    = HW'(1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]  V_ONE    = VW'(1);
  localparam logic [CWW-1:0] CW_LAST  = CWW'(CELL_W - 1);
  localparam logic [CWW-1:0] CW_ONE   = CWW'(1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CELL_H - 1);
  localparam logic [CHW-1:0] CH_ONE   = CHW'(1);

  // stage 0
  logic [HW-1:0]  h;
  logic [VW-1:0]  v;
  logic [CWW-1:0] col_sub;
  logic [4:0]     col;
  logic [CHW-1:0] row_sub;
  logic [4:0]     row;

  // stage 1
  logic active_s1;
  logic hsync_s1;
  logic vsync_s1;
  logic frame_s1;

  // stage 2
  logic       hsync_q;
  logic       vsync_q;
  logic       frame_q;
  logic [2:0] red_q;
  logic [2:0] grn_q;
  logic [2:0] blu_q;

  logic [2:0] level;

  // Cell position is tracked with sub-counters instead of dividing h/v.
  // col/row are 5 bits, so the wrap after cell 31 happens for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h       <= '0;
      v       <= '0;
      col_sub <= '0;
      col     <= '0;
      row_sub <= '0;
      row     <= '0;
    end else if (!i_enable) begin
      h       <= '0;
      v       <= '0;
      col_sub <= '0;
      col     <= '0;
      row_sub <= '0;
      row     <= '0;
    end else if (h == H_LAST) begin
      h       <= '0;
      col_sub <= '0;
      col     <= '0;
      if (v == V_LAST) begin
        v       <= '0;
        row_sub <= '0;
        row     <= '0;
      end else begin
        v <= v + V_ONE;
        // Only visible lines advance the row; after line V_ACTIVE-1 the
        // row has wrapped to 0 and stays there through vertical blanking.
        if (v < V_ACT) begin
          if (row_sub == CH_LAST) begin
            row_sub <= '0;
            row     <= row + 5'd1;
          end else begin
            row_sub <= row_sub + CH_ONE;
          end
        end
      end
    end else begin
      h <= h + H_ONE;
      if (h < H_ACT) begin
        if (col_sub == CW_LAST) begin
          col_sub <= '0;
          col     <= col + 5'd1;
        end else begin
          col_sub <= col_sub + CW_ONE;
        end
      end
    end
  end

  // Stage 1: flags for the pixel whose RAM word arrives next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
      frame_s1  <= 1'b0;
    end else if (!i_enable) begin
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b1;
      vsync_s1  <= 1'b1;
      frame_s1  <= 1'b0;
    end else begin
      active_s1 <= (h < H_ACT) && (v < V_ACT);
      hsync_s1  <= !((h >= H_SS) && (h < H_SE));
      vsync_s1  <= !((v >= V_SS) && (v < V_SE));
      frame_s1  <= (h == '0) && (v == '0);
    end
  end

  // Bright bit selects full (7) or dim (4) intensity for every lit channel.
  assign level = vga.i_data[3] ? 3'd7 : 3'd4;

  // Stage 2: output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
      red_q   <= 3'd0;
      grn_q   <= 3'd0;
      blu_q   <= 3'd0;
    end else if (!i_enable) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_q <= 1'b0;
      red_q   <= 3'd0;
      grn_q   <= 3'd0;
      blu_q   <= 3'd0;
    end else begin
      hsync_q <= hsync_s1;
      vsync_q <= vsync_s1;
      frame_q <= frame_s1;
      if (active_s1) begin
        red_q <= vga.i_data[2] ? level : 3'd0;
        grn_q <= vga.i_data[1] ? level : 3'd0;
        blu_q <= vga.i_data[0] ? level : 3'd0;
      end else begin
        red_q <= 3'd0;
        grn_q <= 3'd0;
        blu_q <= 3'd0;
      end
    end
  end

  assign vga.o_addr        = {row, col};
  assign vga.o_hsync       = hsync_q;
  assign vga.o_vsync       = vsync_q;
  assign vga.o_frame_start = frame_q;
  assign vga.o_red         = red_q;
  assign vga.o_grn         = grn_q;
  assign vga.o_blu         = blu_q;

endmodule

// File: tb/tb_vga_cell_fetch.sv
// tb_vga_cell_fetch
// Directed bench for vga_cell_fetch. A full-size instance covers line-level
// behaviour (addressing, colour, hsync, latency, enable, reset); a second,
// scaled-down instance (80x72 total, 2x2 cells, same 32x32 grid) covers the
// frame-level behaviour (vsync, last row, frame period) in a short run.
// Both RAM models return data one cycle after the address.
module tb_vga_cell_fetch;

  logic clk;
  logic rst_n;
  logic enable;

  vga_cell_fetch_if vga_bus ();
  vga_cell_fetch_if vga_bus_s ();

  vga_cell_fetch dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .vga      (vga_bus.master)
  );

  vga_cell_fetch #(
    .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (64), .V_FP (3), .V_SYNC (2), .V_BP (3),
    .CELL_W   (2),  .CELL_H (2)
  ) dut_s (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .vga      (vga_bus_s.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // RAM content selector: 0 = addr[3:0], 1 = checkerboard, 2 = constant
  int         ram_mode   = 0;
  logic [3:0] const_data = 4'h0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM models (one-cycle read latency) ----------------
  function automatic logic [3:0] ram_word(input logic [9:0] a);
    case (ram_mode)
      0:       return a[3:0];
      1:       return (a[5] ^ a[0]) ? 4'hF : 4'h0;
      default: return const_data;
    endcase
  endfunction

  always @(posedge clk) begin
    vga_bus.i_data   <= ram_word(vga_bus.o_addr);
    vga_bus_s.i_data <= ram_word(vga_bus_s.o_addr);
  end

  // ---------------- reference model ----------------
  function automatic logic [9:0] exp_addr(input int h, input int v, input int cw,
                                          input int ch, input int ha, input int va);
    int r;
    int c;
    r = (v < va) ? (v / ch) : 0;
    c = (h < ha) ? (h / cw) : 0;
    return 10'(((r % 32) * 32) + (c % 32));
  endfunction

  function automatic logic [8:0] colour_of(input logic [3:0] d);
    logic [2:0] lv;
    lv = d[3] ? 3'd7 : 3'd4;
    return {d[2] ? lv : 3'd0, d[1] ? lv : 3'd0, d[0] ? lv : 3'd0};
  endfunction

  // ---------------- drivers ----------------
  // Leaves the bench on a negedge where the counters sit at pixel 0 of a
  // fresh frame (t = 0); after k more negedges the counters are at pixel k
  // and the outputs show pixel k-2.
  task automatic start_scan();
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] rgb;
    ram_mode = 0;
    enable   = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync, vga_bus.o_red, vga_bus.o_grn,
         vga_bus.o_blu, vga_bus.o_frame_start} !== {10'd0, 1'b1, 1'b1, 9'd0, 1'b0})
      $display("FAIL reset_hold: addr=%0d hs=%b vs=%b rgb=%o fs=%b, want 0 1 1 0 0",
               vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync,
               {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, vga_bus.o_frame_start);
    else n_pass++;

    rst_n = 1'b1;
    repeat (305) @(negedge clk);
    // output pixel 303 -> cell 15 -> word F -> white; addr of pixel 305 = 15
    rgb = {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu};
    n_checks++;
    if (rgb !== 9'o777 || vga_bus.o_addr !== 10'd15)
      $display("FAIL pre_reset_pixel: rgb=%o addr=%0d, want 777 15", rgb, vga_bus.o_addr);
    else n_pass++;

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync, vga_bus.o_red, vga_bus.o_grn,
         vga_bus.o_blu, vga_bus.o_frame_start} !== {10'd0, 1'b1, 1'b1, 9'd0, 1'b0})
      $display("FAIL async_reset: addr=%0d hs=%b vs=%b rgb=%o fs=%b, want 0 1 1 0 0",
               vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync,
               {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, vga_bus.o_frame_start);
    else n_pass++;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (vga_bus.o_frame_start !== (j == 2))
        $display("FAIL reset_release_fs: cycle %0d fs=%b want %b", j,
                 vga_bus.o_frame_start, (j == 2));
      else n_pass++;
    end
  endtask

  task automatic test_addressing();
    int h, v, p, ph, pv, low_cnt, first_low;
    logic [9:0] ea;
    logic [9:0] da;
    logic [8:0] erg;
    ram_mode  = 0;
    low_cnt   = 0;
    first_low = -1;
    start_scan();
    for (int t = 1; t <= 12100; t++) begin
      @(negedge clk);
      h  = t % 800;
      v  = t / 800;
      ea = exp_addr(h, v, 20, 15, 640, 480);
      n_checks++;
      if (vga_bus.o_addr !== ea)
        $display("FAIL addr: (%0d,%0d) got %0d want %0d", h, v, vga_bus.o_addr, ea);
      else n_pass++;

      if (t == 19 || t == 20 || t == 639 || t == 640 || t == 12000 || t == 12020) begin
        case (t)
          19:      da = 10'd0;
          20:      da = 10'd1;
          639:     da = 10'd31;
          640:     da = 10'd0;
          12000:   da = 10'd32;
          default: da = 10'd33;
        endcase
        n_checks++;
        if (vga_bus.o_addr !== da)
          $display("FAIL addr_directed: t=%0d got %0d want %0d", t, vga_bus.o_addr, da);
        else n_pass++;
      end

      p = t - 2;
      if (p >= 0) begin
        ph  = p % 800;
        pv  = p / 800;
        erg = (ph < 640 && pv < 480) ?
              colour_of(ram_word(exp_addr(ph, pv, 20, 15, 640, 480))) : 9'd0;
        n_checks++;
        if ({vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu} !== erg)
          $display("FAIL rgb: (%0d,%0d) got %o want %o", ph, pv,
                   {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, erg);
        else n_pass++;
        n_checks++;
        if ({vga_bus.o_hsync, vga_bus.o_vsync, vga_bus.o_frame_start} !==
            {!(ph >= 656 && ph < 752), 1'b1, (ph == 0 && pv == 0)})
          $display("FAIL sync: (%0d,%0d) got hs=%b vs=%b fs=%b", ph, pv,
                   vga_bus.o_hsync, vga_bus.o_vsync, vga_bus.o_frame_start);
        else n_pass++;
        if (pv == 1 && !vga_bus.o_hsync) begin
          low_cnt++;
          if (first_low < 0) first_low = ph;
        end
      end
    end
    n_checks++;
    if (low_cnt !== 96) $display("FAIL hsync_width: got %0d want 96", low_cnt);
    else n_pass++;
    n_checks++;
    if (first_low !== 656) $display("FAIL hsync_start: got %0d want 656", first_low);
    else n_pass++;
  endtask

  task automatic test_colour_map();
    logic [3:0] dv[4] = '{4'hA, 4'h5, 4'hF, 4'h0};
    logic [8:0] ev[4] = '{9'o070, 9'o404, 9'o777, 9'o000};
    ram_mode   = 2;
    const_data = 4'h0;
    start_scan();
    for (int i = 0; i < 4; i++) begin
      const_data = dv[i];
      repeat (3) @(negedge clk);
      n_checks++;
      if ({vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu} !== ev[i])
        $display("FAIL colour_map: data %h got %o want %o", dv[i],
                 {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, ev[i]);
      else n_pass++;
    end
    // now t = 12; move to output pixel 700 (horizontal blanking, inside hsync)
    const_data = 4'hF;
    repeat (690) @(negedge clk);
    n_checks++;
    if ({vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu, vga_bus.o_hsync} !== 10'd0)
      $display("FAIL blank_colour: rgb=%o hs=%b want 0 0",
               {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, vga_bus.o_hsync);
    else n_pass++;
    ram_mode = 0;
  endtask

  task automatic test_latency();
    int x;
    logic [8:0] erg;
    ram_mode = 1;
    start_scan();
    for (int t = 1; t <= 12641; t++) begin
      @(negedge clk);
      if ((t >= 2 && t <= 641) || (t >= 12002)) begin
        x = (t - 2) % 800;
        // line 0: odd cells lit; line 15 (row 1): even cells lit
        if (t <= 641) erg = ((x / 20) % 2 == 1) ? 9'o777 : 9'o000;
        else          erg = ((x / 20) % 2 == 0) ? 9'o777 : 9'o000;
        n_checks++;
        if ({vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu} !== erg)
          $display("FAIL checker_edge: t=%0d x=%0d got %o want %o", t, x,
                   {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, erg);
        else n_pass++;
      end
    end
    ram_mode = 0;
  endtask

  task automatic test_enable();
    int         dh[2]     = '{300, 700};
    int         dvl[2]    = '{3, 0};
    logic [8:0] pre_rgb[2] = '{9'o770, 9'o000};
    logic       pre_hs[2]  = '{1'b1, 1'b0};
    ram_mode = 0;
    for (int k = 0; k < 2; k++) begin
      start_scan();
      repeat (dvl[k] * 800 + dh[k]) @(negedge clk);
      n_checks++;
      if ({vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu, vga_bus.o_hsync} !==
          {pre_rgb[k], pre_hs[k]})
        $display("FAIL pre_disable: case %0d rgb=%o hs=%b want %o %b", k,
                 {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, vga_bus.o_hsync,
                 pre_rgb[k], pre_hs[k]);
      else n_pass++;
      enable = 1'b0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        n_checks++;
        if ({vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync, vga_bus.o_red, vga_bus.o_grn,
             vga_bus.o_blu, vga_bus.o_frame_start} !== {10'd0, 1'b1, 1'b1, 9'd0, 1'b0})
          $display("FAIL enable_blank: case %0d cycle %0d addr=%0d hs=%b vs=%b rgb=%o fs=%b",
                   k, j, vga_bus.o_addr, vga_bus.o_hsync, vga_bus.o_vsync,
                   {vga_bus.o_red, vga_bus.o_grn, vga_bus.o_blu}, vga_bus.o_frame_start);
        else n_pass++;
      end
      enable = 1'b1;
      for (int j = 1; j <= 20; j++) begin
        @(negedge clk);
        n_checks++;
        if (vga_bus.o_frame_start !== (j == 2))
          $display("FAIL reenable_fs: case %0d cycle %0d fs=%b want %b", k, j,
                   vga_bus.o_frame_start, (j == 2));
        else n_pass++;
        if (j == 1 || j == 20) begin
          n_checks++;
          if (vga_bus.o_addr !== ((j == 20) ? 10'd1 : 10'd0))
            $display("FAIL reenable_addr: case %0d cycle %0d got %0d want %0d", k, j,
                     vga_bus.o_addr, (j == 20) ? 1 : 0);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_frame();
    int h, v, p, fs_cnt, vs_low, vs_first;
    int fs_t[4];
    logic [9:0] ea;
    ram_mode = 0;
    fs_cnt   = 0;
    vs_low   = 0;
    vs_first = -1;
    fs_t     = '{0, 0, 0, 0};
    start_scan();
    for (int t = 1; t <= 11524; t++) begin
      @(negedge clk);
      h  = t % 80;
      v  = (t / 80) % 72;
      ea = exp_addr(h, v, 2, 2, 64, 64);
      n_checks++;
      if (vga_bus_s.o_addr !== ea)
        $display("FAIL small_addr: (%0d,%0d) got %0d want %0d", h, v, vga_bus_s.o_addr, ea);
      else n_pass++;
      if (t == 5040 || t == 5103) begin
        n_checks++;
        if (vga_bus_s.o_addr !== ((t == 5040) ? 10'd992 : 10'd1023))
          $display("FAIL last_row_addr: t=%0d got %0d want %0d", t, vga_bus_s.o_addr,
                   (t == 5040) ? 992 : 1023);
        else n_pass++;
      end
      p = t - 2;
      if (vga_bus_s.o_frame_start) begin
        if (fs_cnt < 4) fs_t[fs_cnt] = t;
        fs_cnt++;
      end
      if (p >= 0 && p < 5760 && !vga_bus_s.o_vsync) begin
        vs_low++;
        if (vs_first < 0) vs_first = p;
      end
    end
    n_checks++;
    if (fs_cnt !== 3) $display("FAIL frame_count: got %0d want 3", fs_cnt);
    else n_pass++;
    n_checks++;
    if (fs_t[0] !== 2) $display("FAIL first_frame_pulse: got t=%0d want 2", fs_t[0]);
    else n_pass++;
    n_checks++;
    if (fs_t[1] - fs_t[0] !== 5760 || fs_t[2] - fs_t[1] !== 5760)
      $display("FAIL frame_period: got %0d %0d want 5760", fs_t[1] - fs_t[0],
               fs_t[2] - fs_t[1]);
    else n_pass++;
    n_checks++;
    if (vs_low !== 160) $display("FAIL vsync_width: got %0d want 160", vs_low);
    else n_pass++;
    n_checks++;
    if (vs_first !== 5360) $display("FAIL vsync_start: got %0d want 5360", vs_first);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_addressing();
    test_colour_map();
    test_latency();
    test_enable();
    test_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
